// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu.
// MALU_DIV0_FLAG_EN adds the div_zero response bit.
interface multicycle_alu_if #(parameter int WIDTH = 32);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             busy;
`ifdef MALU_DIV0_FLAG_EN
  logic             div_zero;
`endif

  modport master (
    output in_valid, op, a, b, shamt,
    input  in_ready, out_valid, result, hi, zero, negative, overflow, busy
`ifdef MALU_DIV0_FLAG_EN
    , input div_zero
`endif
  );

  modport slave (
    input  in_valid, op, a, b, shamt,
    output in_ready, out_valid, result, hi, zero, negative, overflow, busy
`ifdef MALU_DIV0_FLAG_EN
    , output div_zero
`endif
  );
endinterface

// File: rtl/multicycle_alu.sv
// EX-stage ALU: single-cycle integer ops plus iterative multiply/divide (1 bit/cycle).
// MALU_DIV0_FLAG_EN: adds div_zero and short-circuits divide-by-zero to a 1-cycle op.
module multicycle_alu #(parameter int WIDTH = 32) (
  input logic             clock,
  input logic             reset,
  multicycle_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2, DONE = 2'd3;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, m_q, a_q;
  logic             div_q, sgn_q, neg_q, a_neg_q, b_zero_q, b_m1_q;
  logic [WIDTH-1:0] result_q, hi_q;
  logic             zero_q, negative_q, overflow_q;

  logic             accept, is_md, is_div, sgn_in, a_neg, b_neg, div0_in, go_iter;
  logic [WIDTH-1:0] a_mag, b_mag, s_res;
  logic             s_ovf;
  logic [WIDTH:0]   msum, dsh, dtr;
  logic [2*WIDTH-1:0] prod;
  logic             wr_en, wr_ovf, wr_dz;
  logic [WIDTH-1:0] wr_res, wr_hi;

  assign accept  = bus.in_valid && (state == IDLE);
  assign is_md   = (bus.op[3:2] == 2'b11);
  assign is_div  = is_md && bus.op[1];
  assign sgn_in  = !bus.op[0];
  assign a_neg   = sgn_in && bus.a[WIDTH-1];
  assign b_neg   = sgn_in && bus.b[WIDTH-1];
  assign a_mag   = a_neg ? -bus.a : bus.a;
  assign b_mag   = b_neg ? -bus.b : bus.b;
  assign div0_in = is_div && (bus.b == '0);
`ifdef MALU_DIV0_FLAG_EN
  assign go_iter = is_md && !div0_in;
`else
  assign go_iter = is_md;
`endif

  always_comb begin
    s_res = '0;
    s_ovf = 1'b0;
    case (bus.op)
      4'd0: begin
        s_res = bus.a + bus.b;
        s_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (s_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'd1: begin
        s_res = bus.a - bus.b;
        s_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (s_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'd2:  s_res = bus.a & bus.b;
      4'd3:  s_res = bus.a | bus.b;
      4'd4:  s_res = bus.a ^ bus.b;
      4'd5:  s_res = ~(bus.a | bus.b);
      4'd6:  s_res = bus.b << bus.shamt;
      4'd7:  s_res = bus.b >> bus.shamt;
      4'd8:  s_res = $signed(bus.b) >>> bus.shamt;
      4'd9:  s_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      4'd10: s_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      4'd11: s_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: ;
    endcase
  end

  // Shift-add step for multiply; restoring-subtract step for divide
  assign msum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : '0);
  assign dsh  = {acc_hi, acc_lo[WIDTH-1]};
  assign dtr  = dsh - {1'b0, m_q};
  assign prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

  always_comb begin
    wr_en  = 1'b0;
    wr_res = s_res;
    wr_hi  = '0;
    wr_ovf = s_ovf;
    wr_dz  = 1'b0;
    if (state == IDLE) begin
      wr_en = accept && !go_iter;
`ifdef MALU_DIV0_FLAG_EN
      if (div0_in) begin
        wr_res = '1;
        wr_hi  = bus.a;
        wr_ovf = 1'b0;
        wr_dz  = 1'b1;
      end
`endif
    end else if (state == FIX) begin
      wr_en  = 1'b1;
      wr_ovf = 1'b0;
      if (!div_q) begin
        wr_res = prod[WIDTH-1:0];
        wr_hi  = prod[2*WIDTH-1:WIDTH];
      end else if (b_zero_q) begin
        wr_res = '1;
        wr_hi  = a_q;
      end else begin
        wr_res = neg_q ? -acc_lo : acc_lo;
        wr_hi  = a_neg_q ? -acc_hi : acc_hi;
        wr_ovf = sgn_q && (a_q == MIN) && b_m1_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      m_q        <= '0;
      a_q        <= '0;
      div_q      <= 1'b0;
      sgn_q      <= 1'b0;
      neg_q      <= 1'b0;
      a_neg_q    <= 1'b0;
      b_zero_q   <= 1'b0;
      b_m1_q     <= 1'b0;
      result_q   <= '0;
      hi_q       <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (go_iter) begin
            state    <= ITER;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= is_div ? a_mag : b_mag;
            m_q      <= is_div ? b_mag : a_mag;
            a_q      <= bus.a;
            div_q    <= is_div;
            sgn_q    <= sgn_in;
            neg_q    <= a_neg ^ b_neg;
            a_neg_q  <= a_neg;
            b_zero_q <= (bus.b == '0);
            b_m1_q   <= &bus.b;
          end else begin
            state <= DONE;
          end
        end
        ITER: begin
          if (div_q) begin
            acc_hi <= dtr[WIDTH] ? dsh[WIDTH-1:0] : dtr[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], !dtr[WIDTH]};
          end else begin
            acc_hi <= msum[WIDTH:1];
            acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH-1)) state <= FIX;
        end
        FIX:     state <= DONE;
        default: state <= IDLE;
      endcase
      if (wr_en) begin
        result_q   <= wr_res;
        hi_q       <= wr_hi;
        zero_q     <= (wr_res == '0);
        negative_q <= wr_res[WIDTH-1];
        overflow_q <= wr_ovf;
      end
    end
  end

`ifdef MALU_DIV0_FLAG_EN
  logic dz_q;
  always_ff @(posedge clock) begin
    if (reset)      dz_q <= 1'b0;
    else if (wr_en) dz_q <= wr_dz;
  end
  assign bus.div_zero = dz_q;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.hi        = hi_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed-vector bench for multicycle_alu at WIDTH=32 (honours MALU_DIV0_FLAG_EN).
module tb_multicycle_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0;
  int lat;
  logic rdy_seen;

  multicycle_alu_if #(.WIDTH(32)) bus ();
  multicycle_alu #(.WIDTH(32)) dut (.clock(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef MALU_DIV0_FLAG_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 34;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Accept one op, then wait (bounded) for its strobe; lat = strobe cycle index
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) chk("ready_timeout", 0, 1);
    bus.op = o; bus.a = x; bus.b = y; bus.shamt = sh; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (bus.in_ready) rdy_seen = 1'b1;
    if (!bus.out_valid) chk("strobe_timeout", 0, 1);
  endtask

  task automatic res(input string tag, input logic [31:0] r, input logic [31:0] h, input int l);
    chk({tag, "_res"}, bus.result, r);
    chk({tag, "_hi"}, bus.hi, h);
    chk({tag, "_lat"}, lat, l);
  endtask

  initial begin
    int strobes;
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.shamt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_rdy", {bus.in_ready, bus.busy}, 2'b10);
    chk("rst_out", {bus.result, bus.hi}, 64'd0);
    chk("rst_flags", {bus.zero, bus.negative, bus.overflow}, 3'b000);
`ifdef MALU_DIV0_FLAG_EN
    chk("rst_dz", bus.div_zero, 0);
`endif

    issue(4'd0, 32'h7FFFFFFF, 32'h1, 0);
    res("add_ovf", 32'h80000000, 0, 1);
    chk("add_flags", {bus.zero, bus.negative, bus.overflow}, 3'b011);

    issue(4'd12, 32'hFFFFFFFE, 32'h3, 0);
    res("mult", 32'hFFFFFFFA, 32'hFFFFFFFF, 34);
    chk("mult_busy", {rdy_seen, bus.busy}, 2'b01);
    chk("mult_flags", {bus.zero, bus.negative, bus.overflow}, 3'b010);
    @(negedge clk);
    chk("strobe_1cyc", {bus.out_valid, bus.in_ready}, 2'b01);
    chk("held", bus.result, 32'hFFFFFFFA);

    issue(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    res("multu", 32'h1, 32'hFFFFFFFE, 34);
    issue(4'd12, 32'h0, 32'h5, 0);
    res("mult0", 0, 0, 34);
    chk("mult0_zero", bus.zero, 1);

    issue(4'd14, 32'hFFFFFFF9, 32'h2, 0);
    res("div", 32'hFFFFFFFD, 32'hFFFFFFFF, 34);
    issue(4'd15, 32'h7, 32'h2, 0);
    res("divu", 32'h3, 32'h1, 34);
    issue(4'd14, 32'h80000000, 32'hFFFFFFFF, 0);
    res("div_min", 32'h80000000, 0, 34);
    chk("div_min_ovf", bus.overflow, 1);

    issue(4'd15, 32'h5, 32'h0, 0);
    res("divu0", 32'hFFFFFFFF, 32'h5, DIV0_LAT);
    chk("divu0_ovf", bus.overflow, 0);
`ifdef MALU_DIV0_FLAG_EN
    chk("divu0_dz", bus.div_zero, 1);
`endif
    issue(4'd14, 32'hFFFFFFF8, 32'h0, 0);
    res("div0", 32'hFFFFFFFF, 32'hFFFFFFF8, DIV0_LAT);

    issue(4'd1, 32'h80000000, 32'h1, 0);
    res("sub_ovf", 32'h7FFFFFFF, 0, 1);
    chk("sub_ovf_f", bus.overflow, 1);
`ifdef MALU_DIV0_FLAG_EN
    chk("sub_dz", bus.div_zero, 0);
`endif
    issue(4'd9, 32'hFFFFFFFF, 32'h1, 0);
    res("slt", 1, 0, 1);
    chk("slt_ovf", bus.overflow, 0);
    issue(4'd10, 32'hFFFFFFFF, 32'h1, 0);
    res("sltu", 0, 0, 1);
    issue(4'd8, 0, 32'h80000000, 4);
    res("sra", 32'hF8000000, 0, 1);
    issue(4'd7, 0, 32'h80000000, 4);
    res("srl", 32'h08000000, 0, 1);
    issue(4'd6, 0, 32'h1, 31);
    res("sll", 32'h80000000, 0, 1);
    issue(4'd11, 32'hDEAD, 32'h12345678, 0);
    res("lui", 32'h56780000, 0, 1);
    issue(4'd5, 32'h0F0F0000, 32'h00000F0F, 0);
    res("nor", 32'hF0F0F0F0, 0, 1);
    issue(4'd4, 32'hFF00FF00, 32'h0FF00FF0, 0);
    res("xor", 32'hF0F0F0F0, 0, 1);
    issue(4'd2, 32'hFF00FF00, 32'h0FF00FF0, 0);
    res("and", 32'h0F000F00, 0, 1);
    issue(4'd3, 32'hFF00FF00, 32'h0FF00FF0, 0);
    res("or", 32'hFFF0FFF0, 0, 1);

    // Reset in cycle 10 of a MULT
    @(negedge clk);
    bus.op = 4'd12; bus.a = 32'd9; bus.b = 32'd9; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rdy", bus.in_ready, 1);
    chk("abort_out", {bus.result, bus.hi}, 64'd0);
    chk("abort_flags", {bus.zero, bus.negative, bus.overflow, bus.out_valid}, 4'b0000);
    strobes = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) strobes++; end
    chk("abort_nostrobe", strobes, 0);
    issue(4'd0, 32'd2, 32'd3, 0);
    res("add_after", 32'd5, 0, 1);

    // SUB held valid through a DIV: accepted only after the DIV strobe
    @(negedge clk);
    bus.op = 4'd14; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.op = 4'd1; bus.a = 32'd1; bus.b = 32'd1;
    lat = 1; strobes = 0;
    while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
    res("div_hold", 32'd14, 32'd2, 34);
    @(negedge clk);
    chk("hold_gap", {bus.out_valid, bus.in_ready}, 2'b01);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("hold_sub_vld", bus.out_valid, 1);
    chk("hold_sub_res", bus.result, 0);
    chk("hold_sub_zero", {bus.zero, bus.overflow}, 2'b10);
    repeat (4) begin @(negedge clk); if (bus.out_valid) strobes++; end
    chk("hold_single", strobes, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
